// File: rtl/msg_event_queue_pkg.sv
// msg_unit_pkg: event type codes, unit sentinel and record field widths for the messaging path
// Record layout is {type[1:0], unit[2:0], block[2:0]}, built by make_rec.
package msg_unit_pkg;
  typedef enum logic [1:0] {EV_RSVD = 2'b00, EV_FAULT = 2'b01, EV_PICKUP = 2'b10, EV_DROP = 2'b11} ev_type_e;
  localparam int UNIT_W = 3;
  localparam int BLK_W = 3;
  localparam int REC_W = 2 + UNIT_W + BLK_W;
  localparam logic [UNIT_W-1:0] UNIT_NONE = 3'd7;
  function automatic logic [REC_W-1:0] make_rec(ev_type_e t, logic [UNIT_W-1:0] u, logic [BLK_W-1:0] b);
    return {t, u, b};
  endfunction
endpackage

// File: rtl/msg_event_queue_if.sv
// msg_event_queue_if: valid/ready byte stream carrying event records
// Ports: msg_data/msg_valid from source, msg_ready from consumer.
interface msg_event_queue_if;
  logic [7:0] msg_data;
  logic msg_valid;
  logic msg_ready;
  modport master(output msg_data, msg_valid, input msg_ready);
  modport slave(input msg_data, msg_valid, output msg_ready);
endinterface

// File: rtl/msg_event_queue_fifo.sv
// msg_fifo: synchronous show-ahead FIFO, writes rejected when full
// Ports: clk/rst_n, wr_en/wr_data, rd_en/rd_data (head, combinational), full, empty, count.
module msg_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_ok, rd_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  // Stale memory is masked so the head reads 0 while empty.
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= wr_data;
endmodule

// File: rtl/msg_event_queue.sv
// msg_event_queue: encodes fault/pick-up/drop edges into byte records, queues them and drives unit LEDs
// Ports: clk_50M, rst_n, unit_active, block_id, fault_detect, em_active, em_drop,
//        msg (record stream), fifo_count, drop_cnt, led_blue, led_green.
module msg_event_queue import msg_unit_pkg::*; #(
  parameter int NUM_UNITS = 3,
  parameter int ID_W = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_HOLD_CYC = 50_000_000
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic [NUM_UNITS-1:0] unit_active,
  input  logic [ID_W-1:0] block_id,
  input  logic fault_detect,
  input  logic em_active,
  input  logic em_drop,
  msg_event_queue_if.master msg,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0] drop_cnt,
  output logic [NUM_UNITS-1:0] led_blue,
  output logic [NUM_UNITS-1:0] led_green
);
  localparam int CW = $clog2(LED_HOLD_CYC + 1);
  logic [2:0] s1, s2, s3, armed, ev, pend, g;
  logic [1:0] warm;
  logic [UNIT_W-1:0] unit;
  logic [REC_W-1:0] cap [3];
  logic [REC_W-1:0] slot [3];
  logic [REC_W-1:0] wr_rec, rd_data;
  logic wr_en, full, empty;
  // Index 0 = fault, 1 = pick-up, 2 = drop throughout.
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      warm <= '0;
      armed <= '0;
    end else begin
      s1 <= {em_drop, em_active, fault_detect};
      s2 <= s1;
      s3 <= s2;
      warm <= {warm[0], 1'b1};
      armed <= armed | ({3{warm[1]}} & ~s2);
    end
  // An edge needs the synchronised level to have been seen low after reset,
  // so an input held high through reset release never fires.
  assign ev = s2 & ~s3 & armed;
  always_comb begin
    unit = UNIT_NONE;
    if ($onehot(unit_active))
      for (int i = 0; i < NUM_UNITS; i++)
        if (unit_active[i]) unit = UNIT_W'(i);
  end
  assign cap[0] = make_rec(EV_FAULT, unit, BLK_W'(block_id));
  assign cap[1] = make_rec(EV_PICKUP, unit, BLK_W'(block_id));
  assign cap[2] = make_rec(EV_DROP, unit, BLK_W'(block_id));
  assign g = {pend[2] & ~|pend[1:0], pend[1] & ~pend[0], pend[0]};
  assign wr_en = |pend;
  assign wr_rec = pend[0] ? slot[0] : pend[1] ? slot[1] : slot[2];
  // A fresh edge overrides the grant clear, so a same-cycle retrigger stays pending.
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      for (int j = 0; j < 3; j++) slot[j] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int j = 0; j < 3; j++)
        if (ev[j]) begin
          pend[j] <= 1'b1;
          slot[j] <= cap[j];
        end else if (g[j]) pend[j] <= 1'b0;
      if (wr_en && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  msg_fifo #(.DATA_W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_50M),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(wr_rec),
    .rd_en(msg.msg_ready),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign msg.msg_data = rd_data;
  assign msg.msg_valid = !empty;
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_led
    logic [CW-1:0] cnt;
    logic grn;
    wire hit = unit == UNIT_W'(u);
    always_ff @(posedge clk_50M or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        grn <= 1'b0;
      end else begin
        cnt <= ev[0] && hit ? CW'(LED_HOLD_CYC) : cnt != '0 ? cnt - CW'(1) : cnt;
        grn <= ev[2] && hit ? 1'b0 : ev[1] && hit ? 1'b1 : grn;
      end
    assign led_blue[u] = cnt != '0;
    assign led_green[u] = grn;
  end
endmodule

// File: tb/tb_msg_event_queue.sv
// tb_msg_event_queue: scoreboard bench for msg_event_queue with directed event scenarios
module tb_msg_event_queue;
  logic clk = 0, rst_n = 0;
  logic [2:0] ua = '0;
  logic [1:0] bid = '0;
  logic fd = 0, ea = 0, ed = 0;
  logic [3:0] fcnt;
  logic [7:0] dcnt, held;
  logic [2:0] lb, lg;
  logic [7:0] exp_q[$];
  int n_chk = 0, n_fail = 0, hi;
  msg_event_queue_if bus();
  msg_event_queue #(.NUM_UNITS(3), .ID_W(2), .FIFO_DEPTH(8), .LED_HOLD_CYC(20)) dut (
    .clk_50M(clk),
    .rst_n(rst_n),
    .unit_active(ua),
    .block_id(bid),
    .fault_detect(fd),
    .em_active(ea),
    .em_drop(ed),
    .msg(bus.master),
    .fifo_count(fcnt),
    .drop_cnt(dcnt),
    .led_blue(lb),
    .led_green(lg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && bus.msg_valid && bus.msg_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_record: got %0h expected none", bus.msg_data);
      end else chk("record", bus.msg_data, exp_q.pop_front());
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.msg_ready = 0;
    tick(3);
    chk("rst_valid", bus.msg_valid, 0);
    chk("rst_count", fcnt, 0);
    chk("rst_drop", dcnt, 0);
    chk("rst_leds", {lb, lg}, 0);
    rst_n = 1;
    tick(3);
    bus.msg_ready = 1; ua = 3'b001; bid = 1; fd = 1;
    exp_q.push_back(8'h41);
    tick();
    fd = 0;
    tick(2);
    chk("fault_blue_on", lb, 3'b001);
    chk("fault_not_yet", bus.msg_valid, 0);
    tick();
    chk("fault_valid", bus.msg_valid, 1);
    chk("fault_data", bus.msg_data, 8'h41);
    hi = 2;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (lb[0]) hi++;
    end
    chk("blue_hold", hi, 20);
    ua = 3'b010; bid = 2; ea = 1;
    exp_q.push_back(8'h8A);
    tick(5);
    chk("green_set", lg, 3'b010);
    ed = 1;
    exp_q.push_back(8'hCA);
    tick(5);
    chk("green_clr", lg, 3'b000);
    ea = 0; ed = 0;
    tick(5);
    chk("pd_drained", fcnt, 0);
    ua = 3'b100; bid = 3; fd = 1; ea = 1; ed = 1;
    exp_q.push_back(8'h53); exp_q.push_back(8'h93); exp_q.push_back(8'hD3);
    tick(4);
    chk("sim_k3", bus.msg_data, 8'h53);
    tick();
    chk("sim_k4", bus.msg_data, 8'h93);
    tick();
    chk("sim_k5", bus.msg_data, 8'hD3);
    tick();
    chk("sim_done", bus.msg_valid, 0);
    fd = 0; ea = 0; ed = 0;
    tick(25);
    bus.msg_ready = 0;
    for (int i = 0; i < 10; i++) begin
      ua = 3'(1 << ((i / 4) % 3)); bid = 2'(i % 4); fd = 1;
      if (i < 8) exp_q.push_back({2'b01, 3'((i / 4) % 3), 3'(i % 4)});
      tick();
      fd = 0;
      tick(3);
    end
    tick(3);
    chk("ovf_count", fcnt, 8);
    chk("ovf_drop", dcnt, 2);
    chk("ovf_head", bus.msg_data, 8'h40);
    held = bus.msg_data;
    tick(3);
    chk("ovf_stable", bus.msg_data, held);
    bus.msg_ready = 1;
    for (int i = 0; i < 50 && bus.msg_valid; i++) tick();
    chk("ovf_empty", fcnt, 0);
    chk("ovf_scoreboard", exp_q.size(), 0);
    tick(25);
    ua = 3'b011; bid = 1; fd = 1;
    exp_q.push_back(8'h79);
    tick();
    fd = 0;
    tick(3);
    chk("inv_blue", lb, 0);
    chk("inv_green", lg, 0);
    tick(3);
    bus.msg_ready = 0; ua = 3'b001; bid = 0;
    for (int i = 0; i < 2; i++) begin
      fd = 1;
      tick();
      fd = 0;
      tick(3);
    end
    ea = 1;
    tick(6);
    chk("pre_rst_count", fcnt, 3);
    chk("pre_rst_green", lg, 3'b001);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", bus.msg_valid, 0);
    chk("arst_data", bus.msg_data, 0);
    chk("arst_count", fcnt, 0);
    chk("arst_drop", dcnt, 0);
    chk("arst_leds", {lb, lg}, 0);
    tick();
    rst_n = 1; bus.msg_ready = 1;
    tick(10);
    chk("held_no_edge", bus.msg_valid, 0);
    chk("held_count", fcnt, 0);
    ea = 0;
    tick(3);
    chk("final_scoreboard", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
